// File: rtl/aes_core_scheduler_if.sv
// Control/status bundle between the AES core scheduler, the register block and the core bank.
interface aes_core_scheduler_if #(
  parameter int NUM_CORES = 8
);
  logic                 I_go;
  logic                 I_always_on;
  logic [NUM_CORES-1:0] I_cores_en;
  logic [7:0]           I_stagger;
  logic [NUM_CORES-1:0] I_core_busy;
  logic [NUM_CORES-1:0] I_core_done;
  logic [NUM_CORES-1:0] O_core_start;
  logic                 O_busy;
  logic                 O_done;
  logic [NUM_CORES-1:0] O_done_mask;
  logic                 O_timeout;
  logic [7:0]           O_last_core;
  logic [15:0]          O_run_count;

  modport master (
    output I_go, I_always_on, I_cores_en, I_stagger, I_core_busy, I_core_done,
    input  O_core_start, O_busy, O_done, O_done_mask, O_timeout, O_last_core, O_run_count
  );

  modport slave (
    input  I_go, I_always_on, I_cores_en, I_stagger, I_core_busy, I_core_done,
    output O_core_start, O_busy, O_done, O_done_mask, O_timeout, O_last_core, O_run_count
  );
endinterface

// File: rtl/aes_core_scheduler.sv
// Staggered start sequencer for a bank of parallel AES cores, with per-core completion
// tracking, run timeout and aggregate busy/done status.
//
//  state | meaning
//  IDLE  | waiting for go or always-on with a non-empty core mask
//  ISSUE | starting the lowest unissued core; holds while that core reports busy
//  GAP   | spacing between consecutive starts, gap_cnt counts down to 1
//  WAIT  | every core started, waiting for all pending dones
//  DONE  | one-cycle end of run: O_done pulse and run counter bump
module aes_core_scheduler #(
  parameter int pNUM_CORES           = 8,
  parameter int pTIMEOUT_WIDTH       = 16,
  parameter int pTIMEOUT             = 4096,
  parameter bit pDONE_EDGE_SENSITIVE = 1'b1
) (
  input logic                  crypto_clk,
  input logic                  reset_n,
  aes_core_scheduler_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [pTIMEOUT_WIDTH-1:0] TMO_LIMIT = pTIMEOUT_WIDTH'(pTIMEOUT);

  logic [2:0]                state_q, state_d;
  logic [pNUM_CORES-1:0]     run_mask_q, run_mask_d;
  logic [pNUM_CORES-1:0]     issued_q, issued_d;
  logic [pNUM_CORES-1:0]     pending_q, pending_d;
  logic [pNUM_CORES-1:0]     done_mask_q, done_mask_d;
  logic [pNUM_CORES-1:0]     start_q, start_d;
  logic [pNUM_CORES-1:0]     done_prev_q, done_prev_d;
  logic [7:0]                gap_cnt_q, gap_cnt_d;
  logic [7:0]                last_core_q, last_core_d;
  logic [pTIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]               run_count_q, run_count_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      timeout_q, timeout_d;

  logic [pNUM_CORES-1:0]     remain, remain_after, tgt_oh, done_ev;
  logic [7:0]                tgt_idx;
  logic                      tgt_vld, tgt_busy, all_done, tmo_hit, end_run;
  logic [pTIMEOUT_WIDTH-1:0] tmo_cnt_inc;

  // Lowest unissued core of the run, its busy status, and this cycle's done events
  always_comb begin
    remain       = run_mask_q & ~issued_q;
    tgt_oh       = remain & (~remain + pNUM_CORES'(1));
    tgt_vld      = |remain;
    remain_after = remain & ~tgt_oh;
    tgt_busy     = |(tgt_oh & bus.I_core_busy);
    tgt_idx      = 8'd0;
    for (int i = 0; i < pNUM_CORES; i++) begin
      if (tgt_oh[i]) tgt_idx = 8'(i);
    end
    done_ev      = pDONE_EDGE_SENSITIVE ? (bus.I_core_done & ~done_prev_q) : bus.I_core_done;
    done_prev_d  = bus.I_core_done;
    all_done     = (issued_q == run_mask_q) && (pending_q == '0);
    // The timeout is measured from the first busy cycle: DONE lands pTIMEOUT cycles after O_busy rises.
    tmo_cnt_inc  = tmo_cnt_q + pTIMEOUT_WIDTH'(1);
    tmo_hit      = (tmo_cnt_inc == TMO_LIMIT);
  end

  // Run sequencing, per-core bookkeeping and status outputs
  always_comb begin
    state_d     = state_q;
    run_mask_d  = run_mask_q;
    issued_d    = issued_q;
    pending_d   = pending_q & ~done_ev;
    done_mask_d = done_mask_q | (done_ev & pending_q);
    start_d     = '0;
    gap_cnt_d   = gap_cnt_q;
    last_core_d = last_core_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    run_count_d = run_count_q;
    done_d      = 1'b0;
    end_run     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((bus.I_go || bus.I_always_on) && (bus.I_cores_en != '0)) begin
          run_mask_d  = bus.I_cores_en;
          issued_d    = '0;
          pending_d   = '0;
          done_mask_d = '0;
          timeout_d   = 1'b0;
          tmo_cnt_d   = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE, S_GAP, S_WAIT: begin
        tmo_cnt_d = tmo_cnt_inc;
        if ((state_q == S_WAIT) && all_done) begin
          end_run = 1'b1;
        end else if (tmo_hit) begin
          end_run   = 1'b1;
          timeout_d = 1'b1;
        end else if (state_q == S_ISSUE) begin
          if (!tgt_vld) begin
            state_d = S_WAIT;
          end else if (!tgt_busy) begin
            // A done seen in this cycle is already ignored for the target, since pending_q is still clear.
            start_d     = tgt_oh;
            issued_d    = issued_q | tgt_oh;
            pending_d   = pending_d | tgt_oh;
            last_core_d = tgt_idx;
            if (remain_after == '0) begin
              state_d = S_WAIT;
            end else if (bus.I_stagger == 8'd0) begin
              state_d = S_ISSUE;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = bus.I_stagger;
            end
          end
        end else if (state_q == S_GAP) begin
          if (gap_cnt_q <= 8'd1) state_d = S_ISSUE;
          else                   gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (end_run) begin
      state_d     = S_DONE;
      done_d      = 1'b1;
      run_count_d = run_count_q + 16'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge crypto_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      run_mask_q  <= '0;
      issued_q    <= '0;
      pending_q   <= '0;
      done_mask_q <= '0;
      start_q     <= '0;
      done_prev_q <= '0;
      gap_cnt_q   <= '0;
      last_core_q <= '0;
      tmo_cnt_q   <= '0;
      run_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_mask_q  <= run_mask_d;
      issued_q    <= issued_d;
      pending_q   <= pending_d;
      done_mask_q <= done_mask_d;
      start_q     <= start_d;
      done_prev_q <= done_prev_d;
      gap_cnt_q   <= gap_cnt_d;
      last_core_q <= last_core_d;
      tmo_cnt_q   <= tmo_cnt_d;
      run_count_q <= run_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.O_core_start = start_q;
  assign bus.O_busy       = busy_q;
  assign bus.O_done       = done_q;
  assign bus.O_done_mask  = done_mask_q;
  assign bus.O_timeout    = timeout_q;
  assign bus.O_last_core  = last_core_q;
  assign bus.O_run_count  = run_count_q;

endmodule
